// File: rtl/eth_pkg.sv
// Shared Ethernet-style framing definitions used by the sender and receiver blocks.
package eth_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PREAMBLE,
    SFD,
    MACDST,
    MACSRC,
    LEN,
    PAYLOAD,
    FCS,
    GAP
  } state_e;

  localparam logic [7:0]  PREAMBLE_OCTET = 8'hAA;
  localparam logic [7:0]  SFD_OCTET      = 8'hAB;

  localparam logic [15:0] PREAMBLE_LEN   = 16'd7;
  localparam logic [15:0] SFD_LEN        = 16'd1;
  localparam logic [15:0] MAC_LEN        = 16'd6;
  localparam logic [15:0] LEN_LEN        = 16'd2;
  localparam logic [15:0] FCS_LEN        = 16'd4;

  // Two's-complement of the running octet sum, so sum + FCS == 0 mod 256.
  function automatic logic [7:0] fcs_of(input logic [7:0] sum);
    return 8'(~sum + 8'd1);
  endfunction

endpackage

// File: rtl/lrc_accum.sv
// Wrapping 8-bit octet sum with its two's-complement check octet.
module lrc_accum
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       add_en_i,
  input  logic [7:0] octet_i,
  output logic [7:0] sum_o,
  output logic [7:0] fcs_o
);

  logic [7:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sum_q <= '0;
    end else if (add_en_i) begin
      sum_q <= sum_q + octet_i;
    end
  end

  assign sum_o = sum_q;
  assign fcs_o = fcs_of(sum_q);

endmodule

// File: rtl/send_top.sv
// Frame sender: preamble, SFD, MAC addresses, length, streamed payload and LRC check octets.
module send_top
  import eth_pkg::*;
#(
  parameter logic [47:0] SRC_MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter int unsigned IFG_CYCLES   = 12
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  input  logic [47:0] req_dst,
  input  logic [15:0] req_len,
  output logic        req_rdy,
  input  logic [7:0]  pl_data,
  input  logic        pl_vld,
  output logic        pl_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        tx_en,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [47:0] dst_q;
  logic [15:0] len_q;
  logic        done_q;
  logic        err_q;

  logic [7:0]  tx_data_c;
  logic        tx_en_c;
  logic        tx_start_c;
  logic        pl_rdy_c;
  logic        add_en;
  logic [7:0]  fcs;
  logic [7:0]  sum_unused;
  logic [47:0] dst_sh;
  logic [47:0] src_sh;

  // Address octets go out MSB first: shift the field left by 8*index and take the top octet.
  assign dst_sh = dst_q << {cnt_q[2:0], 3'b000};
  assign src_sh = SRC_MAC_ADDR << {cnt_q[2:0], 3'b000};

  always_comb begin
    tx_data_c  = '0;
    tx_en_c    = 1'b0;
    tx_start_c = 1'b0;
    pl_rdy_c   = 1'b0;
    case (state_q)
      PREAMBLE: begin
        tx_data_c  = PREAMBLE_OCTET;
        tx_en_c    = 1'b1;
        tx_start_c = (cnt_q == '0);
      end
      SFD: begin
        tx_data_c = SFD_OCTET;
        tx_en_c   = 1'b1;
      end
      MACDST: begin
        tx_data_c = dst_sh[47:40];
        tx_en_c   = 1'b1;
      end
      MACSRC: begin
        tx_data_c = src_sh[47:40];
        tx_en_c   = 1'b1;
      end
      LEN: begin
        tx_data_c = cnt_q[0] ? len_q[7:0] : len_q[15:8];
        tx_en_c   = 1'b1;
      end
      PAYLOAD: begin
        pl_rdy_c  = 1'b1;
        tx_en_c   = pl_vld;
        tx_data_c = pl_vld ? pl_data : 8'h00;
      end
      FCS: begin
        tx_data_c = fcs;
        tx_en_c   = 1'b1;
      end
      default: ;
    endcase
  end

  assign add_en = tx_en_c && (state_q inside {MACDST, MACSRC, LEN, PAYLOAD});

  lrc_accum u_lrc (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == IDLE),
    .add_en_i (add_en),
    .octet_i  (tx_data_c),
    .sum_o    (sum_unused),
    .fcs_o    (fcs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= cnt_q + 16'd1;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (req_vld) begin
            dst_q <= req_dst;
            len_q <= req_len;
            if (req_len == '0) err_q <= 1'b1;
            else               state_q <= PREAMBLE;
          end
        end
        PREAMBLE: if (cnt_q == PREAMBLE_LEN - 16'd1) begin state_q <= SFD;    cnt_q <= '0; end
        SFD:      if (cnt_q == SFD_LEN - 16'd1)      begin state_q <= MACDST; cnt_q <= '0; end
        MACDST:   if (cnt_q == MAC_LEN - 16'd1)      begin state_q <= MACSRC; cnt_q <= '0; end
        MACSRC:   if (cnt_q == MAC_LEN - 16'd1)      begin state_q <= LEN;    cnt_q <= '0; end
        LEN:      if (cnt_q == LEN_LEN - 16'd1)      begin state_q <= PAYLOAD; cnt_q <= '0; end
        PAYLOAD: begin
          // A missing payload octet aborts the frame; the octet count only advances on pl_vld.
          if (!pl_vld) begin
            err_q   <= 1'b1;
            state_q <= GAP;
            cnt_q   <= '0;
          end else if (cnt_q == len_q - 16'd1) begin
            state_q <= FCS;
            cnt_q   <= '0;
          end
        end
        FCS: begin
          if (cnt_q == FCS_LEN - 16'd1) begin
            done_q  <= 1'b1;
            state_q <= GAP;
            cnt_q   <= '0;
          end
        end
        GAP: if (cnt_q == IFG_LAST) begin state_q <= IDLE; cnt_q <= '0; end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Outputs are forced quiet while rst is high so an aborted frame never leaks a partial octet.
  assign req_rdy  = (state_q == IDLE) && !rst;
  assign pl_rdy   = pl_rdy_c && !rst;
  assign tx_en    = tx_en_c && !rst;
  assign tx_start = tx_start_c && !rst;
  assign tx_data  = rst ? 8'h00 : tx_data_c;
  assign done     = done_q && !rst;
  assign err      = err_q && !rst;

endmodule

// File: doc/send_top.md
SEND_TOP -- requirements
Module: send_top

Interface
REQ-001 Parameter SRC_MAC_ADDR, default 48'h02_00_00_00_00_01, source MAC sent in MACSRC field.
REQ-002 Parameter IFG_CYCLES, default 12, idle cycles forced between frames.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_vld  input  1  frame request valid.
REQ-006 req_dst  input  48  destination MAC, MSB octet sent first.
REQ-007 req_len  input  16  payload length in octets.
REQ-008 req_rdy  output  1  block can accept a request.
REQ-009 pl_data  input  8  payload octet.
REQ-010 pl_vld  input  1  payload octet valid.
REQ-011 pl_rdy  output  1  payload octet consumed this cycle.
REQ-012 tx_data  output  8  line octet.
REQ-013 tx_start  output  1  high only with first preamble octet.
REQ-014 tx_en  output  1  tx_data carries a frame octet.
REQ-015 done  output  1  one-cycle pulse, frame completed.
REQ-016 err  output  1  one-cycle pulse, request rejected or frame aborted.

Function
REQ-017 States SHALL be IDLE, PREAMBLE, SFD, MACDST, MACSRC, LEN, PAYLOAD, FCS, GAP; a 16-bit state counter clears on every state change.
REQ-018 req_rdy SHALL be high only in IDLE; request accepted when req_vld&&req_rdy, req_dst/req_len latched that cycle.
REQ-019 Accepted request with req_len==0 SHALL produce no frame, err pulse next cycle, stay IDLE.
REQ-020 Accepted request with req_len!=0 at cycle t SHALL drive first preamble octet at t+1 with tx_start=1.
REQ-021 Field order, one octet per cycle, tx_en=1: PREAMBLE 7x 8'hAA, SFD 1x 8'hAB, MACDST 6 octets, MACSRC 6 octets, LEN 2 octets big-endian, PAYLOAD req_len octets, FCS 4 octets.
REQ-022 FCS octet SHALL be (~S)+1 mod 256, S = 8-bit wrapping sum of all MACDST, MACSRC, LEN and PAYLOAD octets; all 4 FCS octets identical.
REQ-023 In PAYLOAD, pl_rdy=1 and tx_data=pl_data combinationally; octet counted only when pl_vld=1.
REQ-024 Underrun: pl_vld=0 in a PAYLOAD cycle SHALL drive tx_en=0, tx_data=0 that cycle, pulse err next cycle, enter GAP.
REQ-025 Frame complete: done pulses the cycle after last FCS octet; state enters GAP.
REQ-026 GAP SHALL hold tx_en=0 for IFG_CYCLES cycles, then IDLE; requests ignored (req_rdy=0) during GAP.
REQ-027 Outside frame octets tx_data=8'h00, tx_en=0, tx_start=0, pl_rdy=0.
REQ-028 done and err SHALL never be high in the same cycle.
REQ-029 Total tx_en cycles per good frame SHALL equal 26+req_len.

Reset
REQ-030 rst SHALL force IDLE, counter 0, sum 0, latched fields 0 at next edge, including mid-frame.
REQ-031 During and after reset cycle: tx_en=0, tx_start=0, tx_data=0, pl_rdy=0, done=0, err=0, req_rdy=1 from first cycle after rst deasserts.
REQ-032 Reset mid-frame SHALL not emit done or err.

Structure
REQ-033 Package eth_pkg SHALL hold state enum, 8'hAA/8'hAB octet constants, field lengths (7,1,6,6,2,4); shared with receiver.
REQ-034 One sub-module lrc_accum (clear, add-enable, 8-bit octet in, 8-bit sum and FCS out) SHALL compute REQ-022.

Verification
REQ-035 req_dst=48'h00_0a_95_9d_68_16, req_len=3, payload 01 02 03, default SRC -> 29 tx_en octets, FCS 4x 8'h3A, done once; receiver model returns SUCCESS.
REQ-036 req_len=0 -> no tx_en, err pulse one cycle after acceptance, req_rdy stays 1.
REQ-037 pl_vld dropped on 2nd of 4 payload octets -> tx_en low that cycle, err pulse, 12 GAP cycles, then req_rdy=1.
REQ-038 rst asserted during MACSRC -> next cycle all outputs idle, req_rdy=1, no done/err.
REQ-039 Back-to-back requests, req_vld held high -> second tx_start exactly 12 cycles after first frame's last FCS octet plus one IDLE acceptance cycle.
REQ-040 req_len=16'h0100, payload 8'hFF each -> sum wraps correctly, FCS matches reference model, done once.
